cam_capture: RTL and testbench
==============================

# cam_capture

Frame-capture front end for the camera path: samples the sensor's parallel bus (vsync, href, pclk, data[7:0]) in the system clock domain, extracts the luma byte of a YUYV stream, and writes one 4-bit grey pixel per luma byte into the frame-buffer RAM write port. It sits between the sensor pins and the frame-buffer/Wishbone camera peripheral. That peripheral arms it with `start`, waits for `ready`, then reads pixels back by address.

## Interface
- `H_PIXELS`, 320: pixels stored per line.
- `V_LINES`, 240: lines stored per frame.
- `ADDR_W`, 17: frame-buffer address width; must satisfy 2^ADDR_W ≥ H_PIXELS·V_LINES.
- `PIX_W`, 4: stored pixel width; the upper PIX_W bits of the luma byte are kept.
- `clk`  in  1  system clock (50 MHz); the only clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle pulse that arms capture of the next full frame.
- `vsync`  in  1  sensor vsync, asynchronous; high = vertical blanking.
- `href`  in  1  sensor href, asynchronous; high = active line.
- `pclk`  in  1  sensor pixel clock, asynchronous; treated as data and must be ≤ clk/4.
- `data`  in  8  sensor byte, asynchronous; stable around pclk rising edge.
- `wr_en`  out  1  frame-buffer write strobe, one cycle per pixel.
- `wr_addr`  out  ADDR_W  write address = line·H_PIXELS + column.
- `wr_data`  out  PIX_W  pixel value = data[7:8-PIX_W] of the luma byte.
- `ready`  out  1  frame complete and buffer valid.
- `busy`  out  1  armed or capturing.
- `err`  out  1  sticky: at least one line in the last frame had a pixel count ≠ H_PIXELS.

## Operation
- **Input sampling:** vsync, href, pclk and data each pass through two synchronizer flops, plus a third history flop for edge detection. All four share identical stage depth so they stay aligned.
- **Edge strobes:**
  - pclk rise = s2 & ~s3.
  - href fall = ~s2 & s3.
  - vsync fall / vsync rise defined likewise.
- **States:**
  - IDLE → ARMED on `start`.
  - ARMED → CAPTURE on vsync fall (start of active frame).
  - CAPTURE → DONE on vsync rise, or when line counter reaches V_LINES.
  - DONE → ARMED on `start`.
  - `start` is ignored in ARMED and CAPTURE.
- **Byte handling in CAPTURE:**
  - On each pclk rise with href high, a byte toggle flips.
  - Byte toggle cleared at every href fall; even bytes (toggle = 0) are luma.
  - For each luma byte with column < H_PIXELS and line < V_LINES, write pixel to line·H_PIXELS + column, then column++.
  - Luma bytes beyond H_PIXELS are counted but not written.
- **Line handling:** on href fall, if column > 0:
  - line++;
  - err set if column ≠ H_PIXELS;
  - column cleared.
- **Address arithmetic:** kept as a running counter, not a multiply. Incremented per write; realigned to line·H_PIXELS at each line end by a second accumulator stepping by H_PIXELS.
- **Outputs by state:**
  - `ready` = 1 only in DONE.
  - `busy` = 1 in ARMED and CAPTURE.
  - `err` cleared on entry to CAPTURE.
- **Short frame:** a vsync rise before V_LINES lines still ends in DONE. Unwritten addresses keep old contents.

## Timing
- **Reset values:** all outputs 0; state IDLE; counters, toggle and synchronizers 0.
- **Reset mid-frame:** returns to IDLE immediately, with no further writes.
- **Write latency:** a pclk level first sampled high at clk edge k gives a pclk-rise strobe in cycle k+2. `wr_en`, `wr_addr` and `wr_data` are registered and valid for exactly one cycle after edge k+2.
- **Write strobe shape:** `wr_en` is never high on two consecutive cycles, because pclk ≤ clk/4.
- **State updates:** `ready` rises on the cycle after the DONE-causing strobe. The final write (if any) occurs no later than that same cycle.
- **Simultaneous events:**
  - An href fall and a vsync rise in the same cycle close the line first (line++, err update), then enter DONE.
  - A vsync fall in DONE is ignored.

## Structure
- **Package `cam_pkg`:** state encoding (IDLE, ARMED, CAPTURE, DONE) and default H_PIXELS/V_LINES constants.
- **Sub-module `cam_sync`:** parameterised-width two-flop synchronizer with asynchronous active-low reset. Instantiated once for the 11-bit bundle {vsync, href, pclk, data}, followed by the history flop.
- **Top-level `cam_capture`:** FSM, byte toggle, column/line/address counters.

## Test plan
- **Reset:** reset held low, random bus activity → no `wr_en`, `ready` = `busy` = `err` = 0; release and no `start` → stays IDLE.
- **Tiny frame:** H_PIXELS=4, V_LINES=2, pclk = clk/4, `start`, then one frame of 2 lines × 8 bytes, luma bytes 0x10,0x20,…. Required:
  - writes to addresses 0..7;
  - data 1,2,3,4,…;
  - `ready` high after final vsync rise;
  - `err` = 0.
- **Overlength line:** line of 12 bytes at H_PIXELS=4 → only 4 writes for that line, `err` = 1, next line starts at address 4.
- **Short frame:** vsync rises after 1 line → DONE with 4 writes, `ready` = 1. A `start` pulse then re-arms, and `ready` falls the next cycle.
- **Mid-frame events:**
  - `start` pulsed in CAPTURE → ignored, addresses continue.
  - reset asserted mid-line → outputs 0 within the same cycle, no further writes.
- **Arming before frame:** `start` while vsync is low mid-frame → no writes until the next vsync fall.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera capture front end.
// Holds the FSM state encoding and the default frame geometry.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cam_state_t;

    localparam int H_PIXELS_DEF = 320;
    localparam int V_LINES_DEF  = 240;

endpackage

// File: rtl/cam_sync.sv
// cam_sync: W-bit two-flop synchronizer, async active-low reset.
// Ports: clk, reset (0 = reset), d (async in), q (synchronized out).
module cam_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/cam_capture.sv
// cam_capture: samples a YUYV sensor bus and writes 4-bit luma pixels
// into a frame buffer. Ports: clk, reset (0 = reset), start, vsync,
// href, pclk, data -> wr_en, wr_addr, wr_data, ready, busy, err.
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int ADDR_W   = 17,
    parameter int PIX_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              vsync,
    input  logic              href,
    input  logic              pclk,
    input  logic [7:0]        data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    // Column saturates at H_PIXELS+1 so overlong lines never wrap
    // back to a legal-looking count.
    localparam int COL_W  = $clog2(H_PIXELS + 2);
    localparam int LINE_W = $clog2(V_LINES + 1);

    localparam logic [COL_W-1:0]  H_COL  = COL_W'(H_PIXELS);
    localparam logic [COL_W-1:0]  H_SAT  = COL_W'(H_PIXELS + 1);
    localparam logic [LINE_W-1:0] V_LAST = LINE_W'(V_LINES - 1);
    localparam logic [LINE_W-1:0] V_LN   = LINE_W'(V_LINES);
    localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_PIXELS);

    logic [10:0] s2;
    logic [2:0]  s3;

    cam_sync #(.W(11)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({vsync, href, pclk, data}),
        .q     (s2)
    );

    // History stage for edge detection of the control lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3 <= '0;
        end else begin
            s3 <= s2[10:8];
        end
    end

    logic       href_s;
    logic [7:0] sdata;
    logic       pclk_rise;
    logic       href_fall;
    logic       vs_fall;
    logic       vs_rise;
    logic       unused_bits;

    assign href_s      = s2[9];
    assign sdata       = s2[7:0];
    assign pclk_rise   = s2[8] & ~s3[0];
    assign href_fall   = ~s2[9] & s3[1];
    assign vs_fall     = ~s2[10] & s3[2];
    assign vs_rise     = s2[10] & ~s3[2];
    assign unused_bits = ^sdata;

    cam_state_t        state;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] line_base;
    logic              toggle;
    logic              line_end;
    logic              last_line;

    assign line_end  = href_fall && (col != '0);
    assign last_line = line_end && (line == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            col       <= '0;
            line      <= '0;
            addr      <= '0;
            line_base <= '0;
            toggle    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ARMED;
                        busy  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (vs_fall) begin
                        state     <= ST_CAPTURE;
                        err       <= 1'b0;
                        col       <= '0;
                        line      <= '0;
                        addr      <= '0;
                        line_base <= '0;
                        toggle    <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    // pclk_rise needs href_s high and href_fall needs
                    // it low, so these two branches never collide.
                    if (pclk_rise && href_s) begin
                        toggle <= ~toggle;
                        if (!toggle) begin
                            if (col < H_COL && line < V_LN) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= sdata[7 -: PIX_W];
                                addr    <= addr + 1'b1;
                            end
                            if (col != H_SAT) begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                    if (href_fall) begin
                        toggle <= 1'b0;
                        if (col != '0) begin
                            line      <= line + 1'b1;
                            col       <= '0;
                            line_base <= line_base + H_ADDR;
                            addr      <= line_base + H_ADDR;
                            if (col != H_COL) begin
                                err <= 1'b1;
                            end
                        end
                    end
                    if (vs_rise || last_line) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state <= ST_ARMED;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed bench for cam_capture at a 4x2 geometry.
// Drives a YUYV bus at pclk = clk/4 and scoreboards frame writes.
module tb_cam_capture;

    localparam int H = 4;
    localparam int V = 2;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          vsync = 1'b1;
    logic          href = 1'b0;
    logic          pclk = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          ready;
    logic          busy;
    logic          err;

    cam_capture #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .ADDR_W   (AW),
        .PIX_W    (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .vsync   (vsync),
        .href    (href),
        .pclk    (pclk),
        .data    (data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready),
        .busy    (busy),
        .err     (err)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wq_addr[$];
    int wq_data[$];
    int nwrites = 0;
    logic prev_wr = 1'b0;
    int lk = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            tests++;
            if (prev_wr) begin
                fails++;
                $display("FAIL wr_en_single: got 2 consecutive cycles, required 1");
            end
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
            nwrites++;
        end
        prev_wr = wr_en;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data = b;
        pclk = 1'b0;
        tick(2);
        pclk = 1'b1;
        tick(2);
    endtask

    // Even bytes carry luma ((lk+1)&15)<<4, odd bytes chroma 0x80.
    task automatic send_line(input int nbytes, input int smid);
        href = 1'b1;
        tick(2);
        for (int j = 0; j < nbytes; j++) begin
            if (j == smid) pulse_start();
            if (j % 2 == 0) begin
                send_byte(8'(((lk + 1) & 15) << 4));
                lk++;
            end else begin
                send_byte(8'h80);
            end
        end
        pclk = 1'b0;
        tick(2);
        href = 1'b0;
        tick(4);
    endtask

    task automatic frame(input int l0, input int l1, input int smid);
        vsync = 1'b0;
        tick(4);
        send_line(l0, smid);
        if (l1 > 0) send_line(l1, -1);
        vsync = 1'b1;
        tick(4);
    endtask

    task automatic wait_ready(input string nm);
        int w;
        w = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check(nm, int'(ready), 1);
    endtask

    typedef struct {
        int l0;
        int l1;
        int smid;
        int exp_writes;
        int exp_err;
    } vec_t;

    vec_t vecs[5];
    int exp_a[$];
    int exp_d[$];

    initial begin
        vecs[0] = '{l0: 8,  l1: 8, smid: -1, exp_writes: 8, exp_err: 0};
        vecs[1] = '{l0: 12, l1: 8, smid: -1, exp_writes: 8, exp_err: 1};
        vecs[2] = '{l0: 8,  l1: 0, smid: -1, exp_writes: 4, exp_err: 0};
        vecs[3] = '{l0: 6,  l1: 8, smid: -1, exp_writes: 7, exp_err: 1};
        vecs[4] = '{l0: 8,  l1: 8, smid: 3,  exp_writes: 8, exp_err: 0};

        // Reset held with random bus activity: everything stays 0.
        for (int i = 0; i < 16; i++) begin
            vsync = 1'($urandom);
            href  = 1'($urandom);
            pclk  = 1'($urandom);
            data  = 8'($urandom);
            start = 1'($urandom);
            @(negedge clk);
            check("reset_outs", int'({wr_en, ready, busy, err}), 0);
        end
        start = 1'b0;
        vsync = 1'b1;
        href  = 1'b0;
        pclk  = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(4);

        // No start: a full frame produces nothing.
        lk = 0;
        frame(8, 8, -1);
        @(negedge clk);
        check("idle_writes", nwrites, 0);
        check("idle_busy", int'(busy), 0);
        check("idle_ready", int'(ready), 0);

        for (int v = 0; v < 5; v++) begin
            int k;
            int nl;
            wq_addr.delete();
            wq_data.delete();
            exp_a.delete();
            exp_d.delete();
            nwrites = 0;
            lk = 0;
            pulse_start();
            @(negedge clk);
            check($sformatf("v%0d_arm_busy", v), int'(busy), 1);
            check($sformatf("v%0d_arm_ready", v), int'(ready), 0);
            frame(vecs[v].l0, vecs[v].l1, vecs[v].smid);
            wait_ready($sformatf("v%0d_ready", v));
            check($sformatf("v%0d_busy", v), int'(busy), 0);
            check($sformatf("v%0d_err", v), int'(err), vecs[v].exp_err);
            check($sformatf("v%0d_nwr", v), nwrites, vecs[v].exp_writes);
            k = 0;
            nl = (vecs[v].l1 > 0) ? 2 : 1;
            for (int l = 0; l < nl; l++) begin
                int nb;
                int c;
                nb = (l == 0) ? vecs[v].l0 : vecs[v].l1;
                c = 0;
                for (int j = 0; j < nb; j += 2) begin
                    k++;
                    if (c < H) begin
                        exp_a.push_back(l * H + c);
                        exp_d.push_back(k & 15);
                    end
                    c++;
                end
            end
            for (int i = 0; i < exp_a.size(); i++) begin
                if (i < wq_addr.size()) begin
                    check($sformatf("v%0d_addr%0d", v, i), wq_addr[i], exp_a[i]);
                    check($sformatf("v%0d_data%0d", v, i), wq_data[i], exp_d[i]);
                end
            end
        end

        // Arming mid-frame: nothing until the next vsync fall.
        nwrites = 0;
        wq_addr.delete();
        vsync = 1'b0;
        tick(4);
        href = 1'b1;
        tick(2);
        send_byte(8'h50);
        send_byte(8'h80);
        pulse_start();
        for (int j = 0; j < 6; j++) send_byte(8'h60);
        pclk = 1'b0;
        tick(2);
        href = 1'b0;
        tick(4);
        send_line(8, -1);
        vsync = 1'b1;
        tick(4);
        @(negedge clk);
        check("midarm_nwr", nwrites, 0);
        check("midarm_busy", int'(busy), 1);
        lk = 0;
        frame(8, 8, -1);
        wait_ready("midarm_ready");
        check("midarm_nwr2", nwrites, 8);
        if (wq_addr.size() > 0) check("midarm_addr0", wq_addr[0], 0);

        // Reset mid-line: outputs drop at once, no further writes.
        nwrites = 0;
        pulse_start();
        vsync = 1'b0;
        tick(4);
        href = 1'b1;
        tick(2);
        for (int j = 0; j < 4; j++) send_byte(8'h70);
        reset = 1'b0;
        #1;
        check("midrst_outs", int'({wr_en, ready, busy, err}), 0);
        send_byte(8'h70);
        reset = 1'b1;
        for (int j = 0; j < 3; j++) send_byte(8'h70);
        pclk = 1'b0;
        tick(2);
        href = 1'b0;
        tick(4);
        vsync = 1'b1;
        tick(4);
        @(negedge clk);
        check("midrst_nwr", nwrites, 2);
        check("midrst_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
